// File: rtl/nes_joypad_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nes_joypad_pkg
// Brief   : Shared constants for the NES joypad ports (button order, turbo rate)
// Revision: 1.0
// ============================================================================
package nes_joypad_pkg;

    // Serial order of a standard NES pad, bit0 is shifted out first.
    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_U      = 4;
    localparam int BTN_D      = 5;
    localparam int BTN_L      = 6;
    localparam int BTN_R      = 7;

    localparam int NUM_BITS_DEFAULT  = 8;
    localparam int TURBO_DIV_DEFAULT = 378_000;

endpackage : nes_joypad_pkg
`default_nettype wire

// File: rtl/nes_joypad_ports_turbo_phase_gen.sv
`default_nettype none
// ============================================================================
// Module  : turbo_phase_gen
// Brief   : Free-running divider producing the shared turbo phase square wave
// Revision: 1.0
// ============================================================================
module turbo_phase_gen
    import nes_joypad_pkg::*;
#(
    parameter int TURBO_DIV = TURBO_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic o_phase
);

    localparam int C_CNT_W = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(TURBO_DIV - 1);

    logic [C_CNT_W-1:0] r_cnt;
    logic               r_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_phase = r_phase;

endmodule : turbo_phase_gen
`default_nettype wire

// File: rtl/nes_joypad_ports.sv
`default_nettype none
// ============================================================================
// Module  : nes_joypad_ports
// Brief   : Multi-port NES controller shift registers with shared strobe/turbo
// Revision: 1.0
// ============================================================================
module nes_joypad_ports
    import nes_joypad_pkg::*;
#(
    parameter int   NUM_PORTS = 2,
    parameter int   NUM_BITS  = NUM_BITS_DEFAULT,
    parameter int   TURBO_DIV = TURBO_DIV_DEFAULT,
    parameter logic FILL_BIT  = 1'b1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_PORTS*NUM_BITS-1:0]           btn,
    input  logic [NUM_PORTS*NUM_BITS-1:0]           turbo,
    input  logic                                    joypad_strobe,
    input  logic [NUM_PORTS-1:0]                    joypad_clock,
    output logic [NUM_PORTS-1:0]                    joy_data,
    output logic [NUM_PORTS*$clog2(NUM_BITS+1)-1:0] read_count,
    output logic                                    turbo_phase
);

    localparam int C_CNT_W = $clog2(NUM_BITS + 1);
    localparam logic [C_CNT_W-1:0] C_SAT = C_CNT_W'(NUM_BITS);

    logic w_phase;

    turbo_phase_gen #(
        .TURBO_DIV (TURBO_DIV)
    ) u_turbo (
        .clk     (clk),
        .reset   (reset),
        .o_phase (w_phase)
    );

    assign turbo_phase = w_phase;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [NUM_BITS-1:0] r_shift;
        logic [C_CNT_W-1:0]  r_cnt;
        logic                r_last;
        logic [NUM_BITS-1:0] w_eff;
        logic                w_fall;

        assign w_eff  = btn[p*NUM_BITS +: NUM_BITS]
                      | (turbo[p*NUM_BITS +: NUM_BITS] & {NUM_BITS{w_phase}});
        assign w_fall = r_last & ~joypad_clock[p];

        // Strobe has priority over a coincident falling edge.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_shift <= '0;
                r_cnt   <= '0;
                r_last  <= 1'b0;
            end else begin
                r_last <= joypad_clock[p];
                if (joypad_strobe) begin
                    r_shift <= w_eff;
                    r_cnt   <= '0;
                end else if (w_fall) begin
                    r_shift <= {FILL_BIT, r_shift[NUM_BITS-1:1]};
                    if (r_cnt != C_SAT) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end

        assign joy_data[p]                     = r_shift[0];
        assign read_count[p*C_CNT_W +: C_CNT_W] = r_cnt;
    end

endmodule : nes_joypad_ports
`default_nettype wire

// File: tb/tb_nes_joypad_ports.sv
`default_nettype none
// ============================================================================
// Module  : tb_nes_joypad_ports
// Brief   : Self-checking bench: 2x8 and 4x12 builds against a bit-index model
// Revision: 1.0
// ============================================================================
module tb_nes_joypad_ports;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic strobe = 1'b0;

    // Build A: 2 ports x 8 bits, TURBO_DIV=4.  Build B: 4 ports x 12 bits, TURBO_DIV=5.
    logic [15:0] a_btn = '0, a_turbo = '0;
    logic [1:0]  a_jc = '0, a_joy;
    logic [7:0]  a_cnt;
    logic        a_ph;
    logic [47:0] b_btn = '0, b_turbo = '0;
    logic [3:0]  b_jc = '0, b_joy;
    logic [15:0] b_cnt;
    logic        b_ph;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    nes_joypad_ports #(.NUM_PORTS(2), .NUM_BITS(8), .TURBO_DIV(4), .FILL_BIT(1'b1)) dut_a (
        .clk(clk), .reset(reset), .btn(a_btn), .turbo(a_turbo),
        .joypad_strobe(strobe), .joypad_clock(a_jc),
        .joy_data(a_joy), .read_count(a_cnt), .turbo_phase(a_ph)
    );

    nes_joypad_ports #(.NUM_PORTS(4), .NUM_BITS(12), .TURBO_DIV(5), .FILL_BIT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .btn(b_btn), .turbo(b_turbo),
        .joypad_strobe(strobe), .joypad_clock(b_jc),
        .joy_data(b_joy), .read_count(b_cnt), .turbo_phase(b_ph)
    );

    // ---------------- behavioural model ----------------
    // Each port remembers the vector captured at the last strobe and how many
    // bits the CPU has consumed; the visible bit is vector[count] or FILL.
    // Turbo phase is floor(cycles_since_reset / TURBO_DIV) mod 2.
    int          NP[2] = '{2, 4};
    int          NB[2] = '{8, 12};
    int          TD[2] = '{4, 5};
    logic [47:0] in_btn[2], in_turbo[2];
    logic [3:0]  in_jc[2];
    logic [3:0]  act_joy[2];
    logic [15:0] act_cnt[2];
    logic        act_ph[2];

    assign in_btn[0]   = {32'b0, a_btn};
    assign in_btn[1]   = b_btn;
    assign in_turbo[0] = {32'b0, a_turbo};
    assign in_turbo[1] = b_turbo;
    assign in_jc[0]    = {2'b0, a_jc};
    assign in_jc[1]    = b_jc;
    assign act_joy[0]  = {2'b0, a_joy};
    assign act_joy[1]  = b_joy;
    assign act_cnt[0]  = {8'b0, a_cnt};
    assign act_cnt[1]  = b_cnt;
    assign act_ph[0]   = a_ph;
    assign act_ph[1]   = b_ph;

    logic [11:0] m_vec[2][4];
    int          m_cnt[2][4];
    logic        m_last[2][4];
    int          m_k[2];

    function automatic logic model_phase(int i);
        return logic'((m_k[i] / TD[i]) % 2);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_k[i] <= 0;
                for (int p = 0; p < 4; p++) begin
                    m_vec[i][p]  <= '0;
                    m_cnt[i][p]  <= 0;
                    m_last[i][p] <= 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_k[i] <= m_k[i] + 1;
                for (int p = 0; p < NP[i]; p++) begin
                    m_last[i][p] <= in_jc[i][p];
                    if (strobe) begin
                        for (int b = 0; b < NB[i]; b++)
                            m_vec[i][p][b] <= in_btn[i][p*NB[i]+b]
                                            | (in_turbo[i][p*NB[i]+b] & model_phase(i));
                        m_cnt[i][p] <= 0;
                    end else if (m_last[i][p] && !in_jc[i][p]) begin
                        m_cnt[i][p] <= (m_cnt[i][p] < NB[i]) ? m_cnt[i][p] + 1 : NB[i];
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Continuous comparison against the model on every falling clock edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("model_phase[%0d]", i), int'(act_ph[i]), int'(model_phase(i)));
            for (int p = 0; p < NP[i]; p++) begin
                logic e;
                e = (m_cnt[i][p] < NB[i]) ? m_vec[i][p][m_cnt[i][p]] : 1'b1;
                chk($sformatf("model_joy[%0d][%0d]", i, p), int'(act_joy[i][p]), int'(e));
                chk($sformatf("model_cnt[%0d][%0d]", i, p),
                    int'(act_cnt[i][p*4 +: 4]), m_cnt[i][p]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic edge_a(input int p);
        a_jc[p] = 1'b1; tick();
        a_jc[p] = 1'b0; tick();
    endtask

    initial begin
        logic [8:0]  seq;
        logic [47:0] bv;
        logic        prev;
        int          changes;

        tick(); tick();
        #1;
        chk("rst_joy_a", int'(a_joy), 0);
        chk("rst_cnt_a", int'(a_cnt), 0);
        chk("rst_joy_b", int'(b_joy), 0);
        chk("rst_cnt_b", int'(b_cnt), 0);
        chk("rst_phase", int'(a_ph), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Load 8'b1000_0001 on port0 and read nine bits.
        seq = 9'b1_1000_0001;
        a_btn = 16'h0081;
        strobe = 1'b1; tick();
        strobe = 1'b0; tick();
        @(negedge clk);
        chk("load_bit0", int'(a_joy[0]), 1);
        for (int e = 1; e <= 9; e++) begin
            edge_a(0);
            @(negedge clk);
            chk($sformatf("read_bit_after_edge%0d", e), int'(a_joy[0]), int'(seq[(e > 8) ? 8 : e]));
        end
        chk("read_count_sat", int'(a_cnt[3:0]), 8);

        // Port independence.
        a_btn = 16'h0281;
        strobe = 1'b1; tick();
        strobe = 1'b0; tick();
        edge_a(1);
        @(negedge clk);
        chk("p1_first_edge", int'(a_joy[1]), 1);
        chk("p0_bit_kept", int'(a_joy[0]), 1);
        chk("p0_cnt_kept", int'(a_cnt[3:0]), 0);
        edge_a(1);
        @(negedge clk);
        chk("p1_cnt_two", int'(a_cnt[7:4]), 2);
        chk("p0_cnt_still", int'(a_cnt[3:0]), 0);

        // Strobe coincident with a falling edge: reload wins.
        edge_a(0); edge_a(0);
        a_jc[0] = 1'b1; tick();
        a_jc[0] = 1'b0; strobe = 1'b1; tick();
        strobe = 1'b0;
        @(negedge clk);
        chk("coinc_cnt", int'(a_cnt[3:0]), 0);
        chk("coinc_bit", int'(a_joy[0]), 1);

        // Turbo on port0 bit0 with strobe held: joy toggles every 4 cycles.
        a_btn = '0; a_turbo = 16'h0001; strobe = 1'b1;
        tick(); tick();
        @(negedge clk);
        prev = a_joy[0];
        changes = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            @(negedge clk);
            if (a_joy[0] != prev) changes++;
            prev = a_joy[0];
        end
        chk("turbo_toggles_in_16", changes, 4);
        strobe = 1'b0; a_turbo = '0;

        // Reset mid-read with the clock line high.
        a_btn = 16'h00FF;
        strobe = 1'b1; tick();
        strobe = 1'b0; tick();
        edge_a(0); edge_a(0); edge_a(0);
        a_jc[0] = 1'b1; tick();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_joy", int'(a_joy), 0);
        chk("mid_rst_cnt", int'(a_cnt), 0);
        chk("mid_rst_phase", int'(a_ph), 0);
        tick();
        reset = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("post_rst_cnt", int'(a_cnt[3:0]), 0);
        chk("post_rst_joy", int'(a_joy[0]), 0);
        a_jc = '0; tick();

        // Wide build: 12-bit reads on all four ports.
        bv = {16'($urandom), 32'($urandom)};
        b_btn = bv;
        strobe = 1'b1; tick();
        strobe = 1'b0; tick();
        for (int e = 0; e <= 13; e++) begin
            @(negedge clk);
            for (int p = 0; p < 4; p++)
                chk($sformatf("wide_p%0d_e%0d", p, e), int'(b_joy[p]),
                    int'((e < 12) ? bv[p*12+e] : 1'b1));
            b_jc = 4'hF; tick();
            b_jc = 4'h0; tick();
        end
        for (int p = 0; p < 4; p++)
            chk($sformatf("wide_sat_p%0d", p), int'(b_cnt[p*4 +: 4]), 12);

        // Randomized traffic on both builds.
        for (int c = 0; c < 3000; c++) begin
            strobe = ($urandom_range(0, 7) == 0);
            a_jc   = 2'($urandom);
            b_jc   = 4'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                a_btn   = 16'($urandom);
                a_turbo = 16'($urandom);
                b_btn   = {16'($urandom), 32'($urandom)};
                b_turbo = {16'($urandom), 32'($urandom)};
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_nes_joypad_ports
`default_nettype wire
